rtc_bus_sequencer: RTL
======================

Name: rtc_bus_sequencer

Overview:
- Owns the RTC chip's multiplexed address/data bus.
- Arbitrates between three requesters: the initialization walker, the user-write path and the periodic read path.
- Runs each granted request as one two-phase bus transaction: an address phase, then a data phase.
- Drives the chip strobes and the tristate-buffer enable, captures read data, and returns a one-cycle acknowledge to the winning requester.

Parameters:
- T_SU, 1, setup cycles before each strobe pulse (legal range 1..15)
- T_PW, 4, strobe pulse width in cycles (legal range 1..15)
- T_HD, 1, hold cycles after each strobe pulse (legal range 1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- init_req  in  1  initialization request (level)
- init_addr  in  8  register address for init
- init_data  in  8  data for init
- init_ack  out  1  init done pulse
- wr_req  in  1  user write request (level)
- wr_addr  in  8  register address for user write
- wr_data  in  8  data for user write
- wr_ack  out  1  user write done pulse
- rd_req  in  1  read request (level)
- rd_addr  in  8  register address for read
- rd_data  out  8  captured read data
- rd_ack  out  1  read done pulse; rd_data is valid from this cycle
- ad_out  out  8  bus drive value, to the output tristate buffer
- ad_oe  out  1  output tristate buffer enable
- ad_in  in  8  bus value, from the input buffer
- a_d  out  1  0 = address phase, 1 = data phase
- cs_n  out  1  chip select, active-low
- rd_n  out  1  read strobe, active-low
- wr_n  out  1  write strobe, active-low
- busy  out  1  transaction in progress
- owner  out  2  current owner: 0 none, 1 init, 2 wr, 3 rd

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - cs_n = rd_n = wr_n = 1; a_d = 0; ad_oe = 0; ad_out = 0.
  - All acks = 0; rd_data = 0; busy = 0; owner = 0.
  - FSM returns to IDLE; the aborted transaction is never acknowledged.
- FSM states: IDLE, A_SU, A_PW, A_HD, D_SU, D_PW, D_HD, DONE.
  - A phase-cycle counter loads T_SU, T_PW or T_HD on each phase entry.
  - Each phase lasts exactly its parameter count.
- Arbitration (evaluated only in IDLE):
  - init_req has absolute priority.
  - wr and rd use round-robin between themselves. A last-served flag toggles only when a wr or rd transaction completes. Reset value favours wr.
- Grant:
  - Address, data and direction are latched into registers and owner is set.
  - Requester inputs are ignored until DONE.
  - Next state is A_SU.
- Address phase (A_SU, A_PW, A_HD):
  - a_d = 0, ad_oe = 1, ad_out = latched address.
  - cs_n = 0 and wr_n = 0 only in A_PW.
- Data phase, write (D_SU, D_PW, D_HD):
  - a_d = 1, ad_oe = 1, ad_out = latched data.
  - cs_n = 0 and wr_n = 0 only in D_PW.
- Data phase, read:
  - a_d = 1, ad_oe = 0.
  - cs_n = 0 and rd_n = 0 in D_PW.
  - rd_data is captured from ad_in on the last D_PW cycle.
- DONE:
  - Exactly one of init_ack, wr_ack or rd_ack is high for one cycle.
  - busy stays high; all strobes are inactive; ad_oe = 0.
  - Next state is IDLE.
- Latency: with the defaults, ack is high in cycle 14 after the IDLE grant edge. In general: grant + 2×(T_SU+T_PW+T_HD) + 1.
- Back-to-back: the minimum gap between transactions is one IDLE cycle, which gives bus turnaround.
- Requesters must drop req in the cycle after ack. If req is still high in IDLE, it counts as a new request.
- busy = 1 from A_SU through DONE.
- Output timing: all bus outputs are registered, change only on clk edges and are glitch-free. cs_n, rd_n and wr_n never go low in the same cycle that a_d or ad_oe changes.
- Never permitted: rd_n and wr_n both low; ad_oe = 1 while rd_n = 0.

Decomposition:
- Shared package rtc_bus_pkg:
  - state enum
  - owner codes (OWN_NONE, OWN_INIT, OWN_WR, OWN_RD)
  - default timing constants
- Sub-module rtc_phase_timer: loadable 4-bit down-counter with a terminal-count output, reused across all phases.
- The arbiter stays inline.

Test Plan:
- Init write: init_req = 1, addr 0x02, data 0x10 →
  - a_d = 0 with ad_out = 0x02; cs_n/wr_n low for 4 cycles.
  - Then a_d = 1 with ad_out = 0x10; cs_n/wr_n low for 4 cycles.
  - init_ack pulses in cycle 14.
- Read: rd_req, addr 0x21, bench drives ad_in = 0x59 during D_PW →
  - rd_n low for 4 cycles, ad_oe = 0 in the data phase.
  - rd_ack pulses with rd_data = 0x59.
- Simultaneous init, wr and rd held high → grant order init, wr, rd, wr, rd; owner sequence 1, 2, 3, 2, 3.
- Reset mid-transaction: rst low during D_PW of a write →
  - Strobes go high and ad_oe = 0 immediately.
  - No wr_ack is issued.
  - After rst is released, the FSM is in IDLE and the next request completes normally.
- Timing parameters: T_SU = 2, T_PW = 1, T_HD = 3 → ack in cycle 14; each strobe is 1 cycle wide; the one-idle-cycle gap is seen between back-to-back wr requests.
- Assertions held throughout all tests:
  - rd_n and wr_n never both low.
  - ad_oe is never high while rd_n is low.
  - At most one ack is high in any cycle.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg
//   Shared definitions for the RTC multiplexed-bus sequencer:
//   - seq_state_t : sequencer FSM states
//   - OWN_*       : bus owner codes reported on the owner port
//   - DEF_T_*     : default setup / pulse / hold cycle counts
//   - phase_len   : cycle count that the phase timer loads on entry to a state
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SU,
    ST_A_PW,
    ST_A_HD,
    ST_D_SU,
    ST_D_PW,
    ST_D_HD,
    ST_DONE
  } seq_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INIT = 2'd1;
  localparam logic [1:0] OWN_WR   = 2'd2;
  localparam logic [1:0] OWN_RD   = 2'd3;

  localparam int DEF_T_SU = 1;
  localparam int DEF_T_PW = 4;
  localparam int DEF_T_HD = 1;

  // Timed states return their length; IDLE and DONE are untimed and return 0.
  function automatic logic [3:0] phase_len(input seq_state_t st,
                                           input int su,
                                           input int pw,
                                           input int hd);
    logic [3:0] len;
    len = 4'd0;
    case (st)
      ST_A_SU, ST_D_SU: len = 4'(su);
      ST_A_PW, ST_D_PW: len = 4'(pw);
      ST_A_HD, ST_D_HD: len = 4'(hd);
      default:          len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer
//   Loadable 4-bit down-counter shared by every timed bus phase.
//   Ports:
//     clk      in   system clock
//     rst      in   asynchronous reset, active-low
//     load     in   load load_val on the next clock edge
//     load_val in 4 phase length in cycles (1..15)
//     tc       out  high during the last cycle of the loaded phase
module rtc_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       tc
);

  logic [3:0] count;

  // The count holds N in the first cycle of an N-cycle phase and reaches 1 in
  // its last cycle, so terminal count is "count == 1". It parks at 0 while
  // the sequencer sits in an untimed state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign tc = (count == 4'd1);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
//   Owns the RTC chip's multiplexed address/data bus. Arbitrates between the
//   init walker (absolute priority), the user-write path and the periodic read
//   path (round-robin between wr and rd), then runs one address phase and one
//   data phase per grant, each split into setup / strobe pulse / hold.
//   Ports:
//     clk, rst                        clock, asynchronous active-low reset
//     init_req/addr/data, init_ack    init requester (level req, 1-cycle ack)
//     wr_req/addr/data, wr_ack        user write requester
//     rd_req/addr, rd_data, rd_ack    read requester; rd_data valid with rd_ack
//     ad_out, ad_oe, ad_in            bus drive value, drive enable, bus sample
//     a_d                             0 address phase, 1 data phase
//     cs_n, rd_n, wr_n                chip strobes, active-low
//     busy, owner                     transaction status and current owner
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int T_SU = DEF_T_SU,
  parameter int T_PW = DEF_T_PW,
  parameter int T_HD = DEF_T_HD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_req,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_data,
  output logic       init_ack,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_ack,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       a_d,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       busy,
  output logic [1:0] owner
);

  seq_state_t state, next_state;

  logic [7:0] addr_q, data_q;
  logic       is_rd_q;
  logic       last_wr;

  logic [7:0] nxt_addr, nxt_data;
  logic       nxt_is_rd;
  logic [1:0] nxt_owner;

  logic       tmr_load, tmr_tc;
  logic [3:0] tmr_val;

  logic [7:0] n_ad_out;
  logic       n_ad_oe, n_a_d, n_cs_n, n_rd_n, n_wr_n;
  logic       n_init_ack, n_wr_ack, n_rd_ack, n_busy;

  rtc_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the request latch values. Arbitration only happens in
  // IDLE; once granted, the requester inputs are not looked at again until
  // the FSM is back in IDLE. wr wins a wr/rd tie unless it was served last.
  always_comb begin
    next_state = state;
    nxt_addr   = addr_q;
    nxt_data   = data_q;
    nxt_is_rd  = is_rd_q;
    nxt_owner  = owner;
    case (state)
      ST_IDLE: begin
        if (init_req) begin
          nxt_owner  = OWN_INIT;
          nxt_addr   = init_addr;
          nxt_data   = init_data;
          nxt_is_rd  = 1'b0;
          next_state = ST_A_SU;
        end else if (wr_req && (!rd_req || !last_wr)) begin
          nxt_owner  = OWN_WR;
          nxt_addr   = wr_addr;
          nxt_data   = wr_data;
          nxt_is_rd  = 1'b0;
          next_state = ST_A_SU;
        end else if (rd_req) begin
          nxt_owner  = OWN_RD;
          nxt_addr   = rd_addr;
          nxt_data   = 8'h00;
          nxt_is_rd  = 1'b1;
          next_state = ST_A_SU;
        end
      end
      ST_A_SU: if (tmr_tc) next_state = ST_A_PW;
      ST_A_PW: if (tmr_tc) next_state = ST_A_HD;
      ST_A_HD: if (tmr_tc) next_state = ST_D_SU;
      ST_D_SU: if (tmr_tc) next_state = ST_D_PW;
      ST_D_PW: if (tmr_tc) next_state = ST_D_HD;
      ST_D_HD: if (tmr_tc) next_state = ST_DONE;
      ST_DONE: begin
        next_state = ST_IDLE;
        nxt_owner  = OWN_NONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Reload the shared timer on every entry into a timed phase.
  always_comb begin
    tmr_val  = phase_len(next_state, T_SU, T_PW, T_HD);
    tmr_load = (next_state != state) && (tmr_val != 4'd0);
  end

  // Bus outputs are decoded from the state being entered and then registered,
  // so every pin changes only on a clock edge and lines up with its state.
  // Strobes are only ever asserted in PW states, which are bracketed by SU/HD
  // states, so a_d and ad_oe never change in a cycle with a strobe low.
  always_comb begin
    n_ad_out   = 8'h00;
    n_ad_oe    = 1'b0;
    n_a_d      = 1'b0;
    n_cs_n     = 1'b1;
    n_rd_n     = 1'b1;
    n_wr_n     = 1'b1;
    n_init_ack = 1'b0;
    n_wr_ack   = 1'b0;
    n_rd_ack   = 1'b0;
    n_busy     = (next_state != ST_IDLE);
    case (next_state)
      ST_A_SU, ST_A_HD: begin
        n_ad_oe  = 1'b1;
        n_ad_out = nxt_addr;
      end
      ST_A_PW: begin
        n_ad_oe  = 1'b1;
        n_ad_out = nxt_addr;
        n_cs_n   = 1'b0;
        n_wr_n   = 1'b0;
      end
      ST_D_SU, ST_D_HD: begin
        n_a_d = 1'b1;
        if (!nxt_is_rd) begin
          n_ad_oe  = 1'b1;
          n_ad_out = nxt_data;
        end
      end
      ST_D_PW: begin
        n_a_d  = 1'b1;
        n_cs_n = 1'b0;
        if (nxt_is_rd) begin
          n_rd_n = 1'b0;
        end else begin
          n_wr_n   = 1'b0;
          n_ad_oe  = 1'b1;
          n_ad_out = nxt_data;
        end
      end
      ST_DONE: begin
        n_init_ack = (nxt_owner == OWN_INIT);
        n_wr_ack   = (nxt_owner == OWN_WR);
        n_rd_ack   = (nxt_owner == OWN_RD);
      end
      default: ;
    endcase
  end

  // Output registers; reset forces the bus idle immediately, even mid-phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ad_out   <= 8'h00;
      ad_oe    <= 1'b0;
      a_d      <= 1'b0;
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      init_ack <= 1'b0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ad_out   <= n_ad_out;
      ad_oe    <= n_ad_oe;
      a_d      <= n_a_d;
      cs_n     <= n_cs_n;
      rd_n     <= n_rd_n;
      wr_n     <= n_wr_n;
      init_ack <= n_init_ack;
      wr_ack   <= n_wr_ack;
      rd_ack   <= n_rd_ack;
      busy     <= n_busy;
    end
  end

  // Request latches, round-robin memory and read capture. The fairness flag
  // only moves when a wr or rd transaction finishes, so init traffic and
  // aborted transactions leave it alone. Read data is sampled in the last
  // strobe cycle, when the chip has had the full pulse width to drive it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      is_rd_q <= 1'b0;
      owner   <= OWN_NONE;
      last_wr <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      addr_q  <= nxt_addr;
      data_q  <= nxt_data;
      is_rd_q <= nxt_is_rd;
      owner   <= nxt_owner;
      if (state == ST_DONE) begin
        if (owner == OWN_WR) begin
          last_wr <= 1'b1;
        end else if (owner == OWN_RD) begin
          last_wr <= 1'b0;
        end
      end
      if (state == ST_D_PW && tmr_tc && is_rd_q) begin
        rd_data <= ad_in;
      end
    end
  end

endmodule
